prog_loader: RTL and testbench

Bitstream loader that drives the serial configuration chain (`prog_in`/`prog_clk`/`prog_en`) of the fabric's CLB shift registers from a word-wide stream on the system clock. It accepts configuration words via valid/ready, serializes them MSB-first, and generates the divided `prog_clk` with `prog_en` framing. On completion it drops `prog_en` so every chain stage latches its shifted contents at once. It sits between the configuration source (UART/ROM reader) and the head of the CLB chain.

---
 rtl/prog_loader.sv | 175 +++++++++++++++++
 tb/tb_prog_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Serial configuration-chain loader: takes words over valid/ready, shifts them
// MSB-first onto prog_in with a divided prog_clk, framed by prog_en.
module prog_loader #(
  parameter int unsigned CHAIN_LEN = 1000,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              prog_in,
  output logic              prog_clk,
  output logic              prog_en,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int unsigned NWORDS = (CHAIN_LEN + DATA_W - 1) / DATA_W;
  localparam int unsigned ACC_W  = $clog2(NWORDS + 1);
  localparam int unsigned BIT_W  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned PH_W   = $clog2(CLK_DIV + 1);
  localparam int unsigned SH_W   = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL, ABORTED} state_t;
  typedef enum logic [1:0] {PH_WAIT, PH_LOW, PH_HIGH} phase_t;

  state_t            state;
  phase_t            phase;
  logic [DATA_W-1:0] hold_data;
  logic [DATA_W-1:0] sh_word;
  logic              hold_valid;
  logic [SH_W-1:0]   sh_left;
  logic [ACC_W-1:0]  accepted;
  logic [BIT_W-1:0]  bit_cnt;
  logic [PH_W-1:0]   ph_cnt;

  logic             fire, go, kill, finish;
  logic             ph_last, last_bit, bit_avail, need_bit, issue, take_hold;
  logic             hold_valid_n, busy_n;
  logic [ACC_W-1:0] accepted_n;

  assign fire      = s_valid && s_ready;
  assign go        = start && (state == IDLE || state == ABORTED);
  assign kill      = abort && (state == SHIFT || state == TAIL);
  assign finish    = (state == TAIL) && !prog_en;
  assign ph_last   = (ph_cnt == PH_W'(CLK_DIV - 1));
  assign last_bit  = (bit_cnt == BIT_W'(CHAIN_LEN));
  assign bit_avail = (sh_left != '0) || hold_valid;

  // A new bit is wanted while waiting, or when a high phase ends with bits still to send
  assign need_bit  = (state == SHIFT) && !abort &&
                     ((phase == PH_WAIT) || (phase == PH_HIGH && ph_last && !last_bit));
  assign issue     = need_bit && bit_avail;
  assign take_hold = issue && (sh_left == '0);

  // Next-cycle view of the handshake terms so s_ready can be registered
  assign hold_valid_n = (go || kill) ? 1'b0 :
                        fire         ? 1'b1 :
                        take_hold    ? 1'b0 : hold_valid;
  assign accepted_n   = go ? '0 : accepted + ACC_W'(fire);
  assign busy_n       = go ? 1'b1 : (kill || finish) ? 1'b0 : busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= PH_WAIT;
      hold_data  <= '0;
      sh_word    <= '0;
      hold_valid <= 1'b0;
      sh_left    <= '0;
      accepted   <= '0;
      bit_cnt    <= '0;
      ph_cnt     <= '0;
      s_ready    <= 1'b0;
      prog_in    <= 1'b0;
      prog_clk   <= 1'b0;
      prog_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      done       <= 1'b0;
      hold_valid <= hold_valid_n;
      accepted   <= accepted_n;
      busy       <= busy_n;
      s_ready    <= busy_n && !hold_valid_n && (accepted_n < ACC_W'(NWORDS));

      if (fire) hold_data <= s_data;

      // Present the next bit at the start of a low phase
      if (issue) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
        if (take_hold) begin
          prog_in <= hold_data[DATA_W-1];
          sh_word <= hold_data << 1;
          sh_left <= SH_W'(DATA_W - 1);
        end else begin
          prog_in <= sh_word[DATA_W-1];
          sh_word <= sh_word << 1;
          sh_left <= sh_left - SH_W'(1);
        end
      end

      case (state)
        SHIFT: begin
          if (abort) begin
            state    <= ABORTED;
            prog_clk <= 1'b0;
            aborted  <= 1'b1;
          end else begin
            case (phase)
              PH_LOW: begin
                if (ph_last) begin
                  prog_clk <= 1'b1;
                  phase    <= PH_HIGH;
                  ph_cnt   <= '0;
                end else begin
                  ph_cnt <= ph_cnt + PH_W'(1);
                end
              end
              PH_HIGH: begin
                if (ph_last) begin
                  prog_clk <= 1'b0;
                  ph_cnt   <= '0;
                  if (last_bit) begin
                    state <= TAIL;
                    phase <= PH_WAIT;
                  end else begin
                    phase <= issue ? PH_LOW : PH_WAIT;
                  end
                end else begin
                  ph_cnt <= ph_cnt + PH_W'(1);
                end
              end
              default: begin
                if (issue) phase <= PH_LOW;
              end
            endcase
          end
        end
        TAIL: begin
          if (abort) begin
            state    <= ABORTED;
            prog_clk <= 1'b0;
            aborted  <= 1'b1;
          end else if (prog_en) begin
            if (ph_last) prog_en <= 1'b0;
            else         ph_cnt  <= ph_cnt + PH_W'(1);
          end else begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            state    <= SHIFT;
            phase    <= PH_WAIT;
            prog_en  <= 1'b1;
            prog_clk <= 1'b0;
            aborted  <= 1'b0;
            bit_cnt  <= '0;
            sh_left  <= '0;
            ph_cnt   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of load scenarios plus random loads, checked
// against a chain model that shifts on prog_clk rises and latches on prog_en fall.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, s_valid;
  logic [7:0] s_data;
  logic       sel;

  logic a_s_ready, a_prog_in, a_prog_clk, a_prog_en, a_busy, a_done, a_aborted;
  logic b_s_ready, b_prog_in, b_prog_clk, b_prog_en, b_busy, b_done, b_aborted;
  logic m_s_ready, m_prog_in, m_prog_clk, m_prog_en, m_busy, m_done, m_aborted;

  int n_tests, n_fail;

  always #5 clk = ~clk;

  prog_loader #(.CHAIN_LEN(20), .DATA_W(8), .CLK_DIV(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(a_s_ready),
    .prog_in(a_prog_in), .prog_clk(a_prog_clk), .prog_en(a_prog_en),
    .busy(a_busy), .done(a_done), .aborted(a_aborted));

  prog_loader #(.CHAIN_LEN(8), .DATA_W(8), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(b_s_ready),
    .prog_in(b_prog_in), .prog_clk(b_prog_clk), .prog_en(b_prog_en),
    .busy(b_busy), .done(b_done), .aborted(b_aborted));

  assign m_s_ready  = sel ? b_s_ready  : a_s_ready;
  assign m_prog_in  = sel ? b_prog_in  : a_prog_in;
  assign m_prog_clk = sel ? b_prog_clk : a_prog_clk;
  assign m_prog_en  = sel ? b_prog_en  : a_prog_en;
  assign m_busy     = sel ? b_busy     : a_busy;
  assign m_done     = sel ? b_done     : a_done;
  assign m_aborted  = sel ? b_aborted  : a_aborted;

  typedef struct {
    bit          sel;       // 0: CHAIN_LEN=20 CLK_DIV=2, 1: CHAIN_LEN=8 CLK_DIV=1
    logic [31:0] words;     // words offered in order, first word in [31:24]
    int          gap0, gap1, gap2, gap3;
    int          abort_bit; // -1: no abort
    bit          abort_with_start;
    logic [19:0] exp_val;
    bit          chk_fall;
    int          exp_fall;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // First CHAIN_LEN bits of the word stream, first bit ending up as the MSB
  function automatic logic [19:0] model_val(input logic [31:0] w, input int len);
    logic [19:0] r = '0;
    for (int i = 0; i < len; i++) r = {r[18:0], w[31-i]};
    return r;
  endfunction

  task automatic run_load(input vec_t v, input string tag);
    int L, D, nw, e, wi, gap_cnt, acc, rises, dones;
    int fall_edge, done_edge, last_fall, hi_start, last_chg, abort_edge, stop_edge;
    logic pc_prev, pe_prev, pin_prev;
    logic [19:0] chain, latched, mask;
    logic [31:0] wv;
    L  = v.sel ? 8 : 20;
    D  = v.sel ? 1 : 2;
    nw = (L + 7) / 8;
    mask = 20'((1 << L) - 1);
    wv = v.words;
    sel = v.sel;
    @(negedge clk);
    pc_prev = m_prog_clk; pe_prev = m_prog_en; pin_prev = m_prog_in;
    start = 1'b1; abort = v.abort_with_start; s_valid = 1'b0;
    wi = 0; gap_cnt = v.gap0; acc = 0; rises = 0; dones = 0;
    fall_edge = -1; done_edge = -1; last_fall = 0; hi_start = 0; last_chg = 0;
    abort_edge = -1; stop_edge = -1; chain = '0; latched = '0; e = -1;
    while (e < 3000 && (stop_edge < 0 || e < stop_edge)) begin
      @(negedge clk);
      e++;
      start = 1'b0;
      abort = 1'b0;
      if (e == 0) begin
        check({tag, "_start_busy"}, m_busy, 1);
        check({tag, "_start_en"}, m_prog_en, 1);
        check({tag, "_start_aborted"}, m_aborted, 0);
      end
      if (!m_prog_clk && pc_prev) begin
        last_fall = e;
        if (e != abort_edge) begin
          check({tag, "_high_len"}, e - hi_start, D);
          check({tag, "_hold_during_high"}, int'(last_chg <= hi_start), 1);
        end
      end
      if (m_prog_in !== pin_prev) last_chg = e;
      if (m_prog_clk && !pc_prev) begin
        rises++;
        hi_start = e;
        chain = ((chain << 1) | 20'(m_prog_in)) & mask;
        check({tag, "_setup"}, int'((e - last_chg) >= D), 1);
        if (rises == 1) check({tag, "_en_lead"}, int'(e >= D), 1);
      end
      if (!m_prog_en && pe_prev) begin
        fall_edge = e;
        latched = chain;
        check({tag, "_en_tail"}, e - last_fall, D);
        if (v.chk_fall) check({tag, "_fall_edge"}, e, v.exp_fall);
      end
      if (m_done) begin
        dones++;
        if (done_edge < 0) begin
          done_edge = e;
          stop_edge = e + 2;
          check({tag, "_done_edge"}, e, fall_edge + 1);
          check({tag, "_done_busy"}, m_busy, 0);
        end
      end
      if (e == abort_edge) begin
        check({tag, "_abort_clk"}, m_prog_clk, 0);
        check({tag, "_abort_en"}, m_prog_en, 1);
        check({tag, "_abort_flag"}, m_aborted, 1);
        check({tag, "_abort_busy"}, m_busy, 0);
        check({tag, "_abort_ready"}, m_s_ready, 0);
        stop_edge = e + 20;
      end
      if (v.abort_bit >= 0 && abort_edge < 0 && m_prog_clk && !pc_prev &&
          rises == v.abort_bit + 1) begin
        abort = 1'b1;
        abort_edge = e + 1;
      end
      // Source: optional idle gap before each word, then keep offering extra words
      if (wi < 4 && gap_cnt > 0) begin
        s_valid = 1'b0;
        gap_cnt--;
      end else begin
        s_valid = 1'b1;
        s_data  = (wi < 4) ? wv[31-8*wi -: 8] : 8'hEE;
      end
      if (s_valid && m_s_ready) begin
        acc++;
        wi++;
        gap_cnt = (wi == 1) ? v.gap1 : (wi == 2) ? v.gap2 : (wi == 3) ? v.gap3 : 0;
      end
      pc_prev = m_prog_clk; pe_prev = m_prog_en; pin_prev = m_prog_in;
    end
    s_valid = 1'b0;
    check({tag, "_completed_in_budget"}, int'(stop_edge >= 0), 1);
    if (v.abort_bit >= 0) begin
      check({tag, "_abort_no_done"}, dones, 0);
      check({tag, "_abort_rises"}, rises, v.abort_bit + 1);
      check({tag, "_abort_en_held"}, m_prog_en, 1);
      check({tag, "_abort_level"}, m_aborted, 1);
    end else begin
      check({tag, "_rises"}, rises, L);
      check({tag, "_dones"}, dones, 1);
      check({tag, "_words"}, acc, nw);
      check({tag, "_latched"}, latched, v.exp_val);
      check({tag, "_end_aborted"}, m_aborted, 0);
      check({tag, "_end_busy"}, m_busy, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int L;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0; sel = 1'b0;
    n_tests = 0; n_fail = 0;

    tbl[0] = '{1'b0, 32'hA53CF0EE, 0, 0,  0, 0, -1, 1'b0, 20'hA53CF, 1'b1, 84};
    tbl[1] = '{1'b0, 32'hA53CF0EE, 0, 40, 0, 0, -1, 1'b0, 20'hA53CF, 1'b1, 93};
    tbl[2] = '{1'b0, 32'hA53CF0EE, 0, 0,  0, 0, 10, 1'b0, 20'h00000, 1'b0, 0};
    tbl[3] = '{1'b0, 32'h123456EE, 0, 0,  0, 0, -1, 1'b1, 20'h12345, 1'b1, 84};
    tbl[4] = '{1'b1, 32'h81EEEEEE, 0, 0,  0, 0, -1, 1'b1, 20'h00081, 1'b1, 19};
    tbl[5] = '{1'b0, 32'hFF00AB77, 0, 0,  0, 0, -1, 1'b0, 20'hFF00A, 1'b1, 84};
    tbl[6] = '{1'b1, 32'h5A000000, 5, 0,  0, 0, -1, 1'b0, 20'h0005A, 1'b1, 24};

    repeat (3) @(negedge clk);
    check("reset_outputs_a", {a_s_ready, a_prog_in, a_prog_clk, a_prog_en, a_busy, a_done, a_aborted}, 0);
    check("reset_outputs_b", {b_s_ready, b_prog_in, b_prog_clk, b_prog_en, b_busy, b_done, b_aborted}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs_a", {a_s_ready, a_prog_en, a_busy, a_done, a_aborted}, 0);

    for (int i = 0; i < 7; i++) run_load(tbl[i], $sformatf("v%0d", i));

    // Asynchronous reset between edges in the middle of a load
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1; s_valid = 1'b1; s_data = 8'hC3;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    check("rst_mid_busy", a_busy, 1);
    check("rst_mid_en", a_prog_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {a_s_ready, a_prog_in, a_prog_clk, a_prog_en, a_busy, a_done, a_aborted}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_idle_ready", a_s_ready, 0);
      check("rst_idle_busy", a_busy, 0);
    end
    s_valid = 1'b0;
    run_load(tbl[0], "post_rst");

    for (int r = 0; r < 8; r++) begin
      v.sel = 1'($urandom_range(0, 1));
      L = v.sel ? 8 : 20;
      v.words = $urandom;
      v.gap0 = $urandom_range(0, 45);
      v.gap1 = $urandom_range(0, 45);
      v.gap2 = $urandom_range(0, 45);
      v.gap3 = $urandom_range(0, 45);
      v.abort_bit = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, L - 1)) : -1;
      v.abort_with_start = 1'($urandom_range(0, 1));
      v.exp_val = model_val(v.words, L);
      v.chk_fall = 1'b0;
      v.exp_fall = 0;
      run_load(v, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
